flash_cmd_sequencer: RTL and testbench
======================================

Name: flash_cmd_sequencer

Overview:
- Controller that sequences the flash write-byte mux.
- Turns one host command into the ordered byte stream AA, 55, command code, then optional data bytes, by driving the mux one-hot selects one byte at a time.
- Paces each byte against the I2C byte-transmit handshake, then waits for the flash busy flag to clear.
- Sits between the host command interface and the write mux / I2C byte shifter.

Parameters:
- MAX_LEN, 16, maximum data bytes per PROGRAM command.
- LEN_W, 5, width of cmdLen; must hold MAX_LEN.
- TMO_CYC, 4096, SCL cycles allowed in WAIT_BUSY before timeout (used only with the optional feature).

Ports:
- SCL  input  1  sole clock; all state updates on posedge. The mux samples on negedge, so selects are stable half a cycle earlier.
- rst_n  input  1  asynchronous, active-low reset.
- cmdValid  input  1  host command request.
- cmdReady  output  1  sequencer idle and able to accept a command.
- cmdOp  input  2  0=PROGRAM (B0), 1=SECTOR_ERASE (C0), 2=CHIP_ERASE (D0), 3=RESET (E0).
- cmdLen  input  LEN_W  PROGRAM data byte count, 1..MAX_LEN; ignored for other ops.
- dataReq  output  1  pulse requesting the next host data byte.
- dataAvail  input  1  host data byte present on the mux dataIn.
- byteValid  output  1  current select is valid; shifter may send the byte.
- byteAck  input  1  1-cycle pulse: shifter has finished the byte.
- selData, selAA, sel55, selB0, selC0, selD0, selE0  output  1 each  one-hot mux selects.
- flashBusy  input  1  flash internal operation in progress.
- done  output  1  1-cycle completion pulse.
- err  output  1  sticky error, cleared on next accepted command.

Behaviour:
- Reset (async, rst_n low): state=IDLE; all sel*=0; byteValid=0; dataReq=0; done=0; err=0; cmdReady=1; byte counter=0; timeout counter=0. Asserting reset mid-sequence aborts immediately with no partial completion.
- At most one sel* is high at any time. byteValid=1 exactly while a sel* is high.
- IDLE: cmdReady=1. cmdValid&cmdReady latches cmdOp/cmdLen and clears err, giving the handshake.
  - cmdLen=0 or cmdLen>MAX_LEN with PROGRAM: err=1, done pulses the next cycle, stay IDLE.
  - Otherwise go to UNL1.
- UNL1: selAA=1; on byteAck -> UNL2.
- UNL2: sel55=1; on byteAck -> CMD.
- CMD: select matching the op; on byteAck -> DREQ if PROGRAM, else WAIT_BUSY.
- DREQ: dataReq pulses one cycle on entry; wait for dataAvail -> DATA.
- DATA: selData=1; on byteAck, counter+1.
  - If counter+1==cmdLen -> WAIT_BUSY.
  - Else -> DREQ.
  - Counter saturates; never wraps.
- WAIT_BUSY: all selects low. flashBusy=0 sampled -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Minimum latency from command acceptance to done, with 0-cycle acks and flashBusy=0: 6 cycles for erase/reset, +2 cycles per PROGRAM data byte.
- cmdValid while not in IDLE: ignored (cmdReady=0); not queued.
- byteAck outside UNL1/UNL2/CMD/DATA: ignored.
- byteAck and dataAvail together in DREQ: dataAvail wins; that ack is ignored.

Optional Feature:
- Macro: FLASH_SEQ_TIMEOUT_EN.
- Defined:
  - WAIT_BUSY counts cycles while flashBusy=1.
  - On reaching TMO_CYC: err=1, go to DONE (done still pulses).
  - Counter clears on WAIT_BUSY entry.
- Undefined: no counter; WAIT_BUSY waits indefinitely; err only from bad cmdLen.

Decomposition:
- Shared package flash_pkg:
  - command op encodings;
  - byte constants AA, 55, B0, C0, D0, E0;
  - state enum;
  - MAX_LEN default.
- One natural sub-module, flash_busy_timer: timeout counter with clear and expire outputs, instantiated only under FLASH_SEQ_TIMEOUT_EN.

Test Plan:
- SECTOR_ERASE, ack 2 cycles after each byteValid, flashBusy high 10 cycles -> selects in order AA, 55, C0; one done pulse; err=0.
- PROGRAM cmdLen=3, dataAvail 1 cycle after each dataReq -> AA, 55, B0, then three selData bytes; exactly 3 dataReq pulses; done after flashBusy falls.
- PROGRAM cmdLen=0 and cmdLen=MAX_LEN+1 -> no selects asserted; err=1; done pulse; next valid CHIP_ERASE clears err and emits AA, 55, D0.
- cmdValid held high during an active RESET sequence -> second command not accepted until IDLE; byte stream AA, 55, E0 unaffected.
- rst_n low during DATA byte 2 of 4 -> all outputs 0 asynchronously; after release cmdReady=1; no done pulse.
- With FLASH_SEQ_TIMEOUT_EN and TMO_CYC=16, flashBusy stuck high -> err=1 and done exactly 16 cycles after WAIT_BUSY entry. Without the macro: no done after 1000 cycles.

Source files
------------

// File: rtl/flash_pkg.sv
// flash_pkg: shared op encodings, flash byte constants, sequencer states and helpers.
package flash_pkg;

    localparam logic [1:0] OP_PROGRAM      = 2'd0;
    localparam logic [1:0] OP_SECTOR_ERASE = 2'd1;
    localparam logic [1:0] OP_CHIP_ERASE   = 2'd2;
    localparam logic [1:0] OP_RESET        = 2'd3;

    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_55 = 8'h55;
    localparam logic [7:0] BYTE_B0 = 8'hB0;
    localparam logic [7:0] BYTE_C0 = 8'hC0;
    localparam logic [7:0] BYTE_D0 = 8'hD0;
    localparam logic [7:0] BYTE_E0 = 8'hE0;

    localparam int MAX_LEN_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_UNL1, S_UNL2, S_CMD, S_DREQ, S_DATA, S_WAIT_BUSY, S_DONE
    } state_t;

    function automatic logic [7:0] op_code(input logic [1:0] op);
        return op == OP_PROGRAM      ? BYTE_B0 :
               op == OP_SECTOR_ERASE ? BYTE_C0 :
               op == OP_CHIP_ERASE   ? BYTE_D0 : BYTE_E0;
    endfunction

    // Constant byte the mux must present in a given state; 00 where no constant applies.
    function automatic logic [7:0] cur_byte(input state_t st, input logic [1:0] op);
        return st == S_UNL1 ? BYTE_AA :
               st == S_UNL2 ? BYTE_55 :
               st == S_CMD  ? op_code(op) : 8'h00;
    endfunction

endpackage

// File: rtl/flash_busy_timer.sv
// flash_busy_timer: counts enabled cycles, flags expiry on the TMO_CYC-th one.
//   clk, rst_n : clock, async active-low reset
//   clr        : hold the count at zero
//   en         : count this cycle (flash still busy)
//   expire     : this enabled cycle is the TMO_CYC-th since clear
module flash_busy_timer #(
    parameter int TMO_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = en && cnt_q == CNT_W'(TMO_CYC - 1);

    always_comb begin
        cnt_d = clr ? '0 : (en && !expire) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer: turns a host command into the AA,55,cmd[,data...] byte stream on the write mux.
//   SCL, rst_n          : clock (posedge), async active-low reset
//   cmdValid/cmdReady   : host command handshake; cmdOp, cmdLen latched on accept
//   dataReq/dataAvail   : per-byte host data request / data present
//   byteValid/byteAck   : select valid to shifter / shifter finished byte
//   sel*                : one-hot mux selects
//   flashBusy           : flash internal operation in progress
//   done, err           : completion pulse, sticky error
// Optional: FLASH_SEQ_TIMEOUT_EN bounds WAIT_BUSY to TMO_CYC busy cycles.
module flash_cmd_sequencer
    import flash_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = 5,
    parameter int TMO_CYC = 4096
) (
    input  logic             SCL,
    input  logic             rst_n,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [1:0]       cmdOp,
    input  logic [LEN_W-1:0] cmdLen,
    output logic             dataReq,
    input  logic             dataAvail,
    output logic             byteValid,
    input  logic             byteAck,
    output logic             selData,
    output logic             selAA,
    output logic             sel55,
    output logic             selB0,
    output logic             selC0,
    output logic             selD0,
    output logic             selE0,
    input  logic             flashBusy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d, done_q, done_d;
    logic             cmd_ready_q, cmd_ready_d, byte_valid_q, byte_valid_d, data_req_q, data_req_d;
    logic [6:0]       sel_q, sel_d;
    logic [7:0]       byte_d;
    logic             bad_len, tmo_fire;

`ifdef FLASH_SEQ_TIMEOUT_EN
    flash_busy_timer #(.TMO_CYC(TMO_CYC)) u_timer (
        .clk    (SCL),
        .rst_n  (rst_n),
        .clr    (state_q != S_WAIT_BUSY),
        .en     (flashBusy),
        .expire (tmo_fire)
    );
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYC;
    assign tmo_fire   = 1'b0;
`endif

    assign bad_len = cmdOp == OP_PROGRAM && (cmdLen == '0 || cmdLen > LEN_W'(MAX_LEN));
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (cmdValid) begin
                op_d    = cmdOp;
                len_d   = cmdLen;
                cnt_d   = '0;
                err_d   = bad_len;
                done_d  = bad_len;
                state_d = bad_len ? S_IDLE : S_UNL1;
            end
            S_UNL1: if (byteAck) state_d = S_UNL2;
            S_UNL2: if (byteAck) state_d = S_CMD;
            S_CMD:  if (byteAck) state_d = op_q == OP_PROGRAM ? S_DREQ : S_WAIT_BUSY;
            // dataAvail alone moves DREQ on, so a coincident byteAck is dropped.
            S_DREQ: if (dataAvail) state_d = S_DATA;
            S_DATA: if (byteAck) begin
                cnt_d   = cnt_inc;
                state_d = cnt_inc == len_q ? S_WAIT_BUSY : S_DREQ;
            end
            S_WAIT_BUSY: begin
                err_d   = err_q || (flashBusy && tmo_fire);
                state_d = (!flashBusy || tmo_fire) ? S_DONE : S_WAIT_BUSY;
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        byte_d       = cur_byte(state_d, op_d);
        done_d       = done_d || state_d == S_DONE;
        cmd_ready_d  = state_d == S_IDLE;
        data_req_d   = state_d == S_DREQ && state_q != S_DREQ;
        sel_d        = {state_d == S_DATA, byte_d == BYTE_AA, byte_d == BYTE_55, byte_d == BYTE_B0,
                        byte_d == BYTE_C0, byte_d == BYTE_D0, byte_d == BYTE_E0};
        byte_valid_d = |sel_d;
    end

    always_ff @(posedge SCL or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= OP_PROGRAM;
            len_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            byte_valid_q <= 1'b0;
            data_req_q   <= 1'b0;
            sel_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            done_q       <= done_d;
            cmd_ready_q  <= cmd_ready_d;
            byte_valid_q <= byte_valid_d;
            data_req_q   <= data_req_d;
            sel_q        <= sel_d;
        end
    end

    assign cmdReady  = cmd_ready_q;
    assign dataReq   = data_req_q;
    assign byteValid = byte_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign {selData, selAA, sel55, selB0, selC0, selD0, selE0} = sel_q;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer: table vectors, hand sequences and random commands against a byte-stream model.
module tb_flash_cmd_sequencer;

    localparam int MAXL = 16;

    logic       SCL = 1'b0, rst_n = 1'b0;
    logic       cmdValid = 1'b0, cmdReady;
    logic [1:0] cmdOp = 2'd0;
    logic [4:0] cmdLen = 5'd0;
    logic       dataReq, dataAvail = 1'b0, byteValid, byteAck = 1'b0;
    logic       selData, selAA, sel55, selB0, selC0, selD0, selE0;
    logic       flashBusy = 1'b0, done, err;

    flash_cmd_sequencer #(.MAX_LEN(MAXL), .LEN_W(5), .TMO_CYC(16)) dut (
        .SCL(SCL), .rst_n(rst_n), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
        .cmdLen(cmdLen), .dataReq(dataReq), .dataAvail(dataAvail), .byteValid(byteValid),
        .byteAck(byteAck), .selData(selData), .selAA(selAA), .sel55(sel55), .selB0(selB0),
        .selC0(selC0), .selD0(selD0), .selE0(selE0), .flashBusy(flashBusy), .done(done), .err(err)
    );

    always #5 SCL = ~SCL;

    int errors = 0, checks = 0;
    int cyc = 0, ndone = 0, ndreq = 0, ohbad = 0, rdybad = 0, done_cyc = 0;
    int ack_d = 0, av_d = 0, busy_n = 0, exp_n = 0, vw = 0, bc = 0, av_cnt = 0;
    bit stray = 0, stuck = 0, in_seq = 0, av_pend = 0, prev_err = 0;
    logic err_at_done = 1'b0;
    logic [6:0] got[$];

    typedef struct {
        logic [1:0] op;
        logic [4:0] len;
        int         ack, av, busy;
        bit         hold;
        int         lat;
        bit         err;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Spec model: AA, 55, command code, then one data byte per PROGRAM length unit.
    function automatic logic [6:0] exp_sel(input logic [1:0] op, input int idx);
        logic [6:0] cmd_sel;
        cmd_sel = 7'b0001000 >> op;
        return idx == 0 ? 7'b0100000 : idx == 1 ? 7'b0010000 : idx == 2 ? cmd_sel : 7'b1000000;
    endfunction

    function automatic bit is_bad(input logic [1:0] op, input logic [4:0] len);
        return op == 2'd0 && (len == 0 || int'(len) > MAXL);
    endfunction

    // Cycles from the accept cycle to the done cycle inclusive.
    function automatic int lat_model(input logic [1:0] op, input logic [4:0] len, input int a, input int v, input int b);
        if (is_bad(op, len)) return 2;
        return 1 + 3 * (a + 1) + (op == 2'd0 ? int'(len) * (v + a + 2) : 0) + b + 1 + 1;
    endfunction

    // Shifter, host data source and flash model plus output monitor.
    always @(negedge SCL) begin
        logic [6:0] sv;
        cyc++;
        byteAck = 1'b0;
        dataAvail = 1'b0;
        sv = {selData, selAA, sel55, selB0, selC0, selD0, selE0};
        if (!$onehot0(sv) || (|sv) != byteValid) ohbad++;
        if (in_seq && cmdReady) rdybad++;
        if (done) begin
            if (ndone == 0) done_cyc = cyc;
            ndone++;
            err_at_done = err;
            in_seq = 0;
        end
        if (dataReq) begin
            ndreq++;
            av_pend = 1;
            av_cnt = av_d;
        end
        flashBusy = stuck || bc > 0;
        if (bc > 0) bc--;
        if (byteValid) begin
            if (vw == ack_d) begin
                byteAck = 1'b1;
                got.push_back(sv);
                vw = 0;
                if (got.size() == exp_n) bc = busy_n;
            end else vw++;
        end else begin
            vw = 0;
            byteAck = stray && $urandom_range(0, 1) == 1;
        end
        if (av_pend) begin
            if (av_cnt == 0) begin
                dataAvail = 1'b1;
                av_pend = 0;
            end else av_cnt--;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] len, output int t0);
        @(negedge SCL);
        #1;
        chk("ready_idle", int'(cmdReady), 1);
        cmdOp = op;
        cmdLen = len;
        cmdValid = 1'b1;
        t0 = cyc;
        @(posedge SCL);
        #1;
    endtask

    task automatic run(input logic [1:0] op, input logic [4:0] len, input bit hold, input int exp_lat, input bit exp_err);
        int  t0;
        bit  bad;
        bad = is_bad(op, len);
        got.delete();
        ndone = 0; ndreq = 0; ohbad = 0; rdybad = 0;
        exp_n = bad ? 0 : 3 + (op == 2'd0 ? int'(len) : 0);
        chk("err_sticky", int'(err), int'(prev_err));
        issue(op, len, t0);
        in_seq = !bad;
        if (!hold) cmdValid = 1'b0;
        for (int i = 0; i < 3000 && ndone == 0; i++) @(posedge SCL);
        #1;
        cmdValid = 1'b0;
        repeat (3) @(posedge SCL);
        #1;
        chk("done_cnt", ndone, 1);
        chk("latency", done_cyc - t0 + 1, exp_lat);
        chk("err", int'(err_at_done), int'(exp_err));
        chk("dreq_cnt", ndreq, bad ? 0 : (op == 2'd0 ? int'(len) : 0));
        chk("nbytes", got.size(), exp_n);
        for (int i = 0; i < got.size() && i < exp_n; i++) chk($sformatf("byte%0d", i), int'(got[i]), int'(exp_sel(op, i)));
        chk("onehot", ohbad, 0);
        chk("ready_busy", rdybad, 0);
        chk("ready_after", int'(cmdReady), 1);
        prev_err = exp_err;
    endtask

    vec_t tbl[10];

    initial begin
        int t0;
        tbl[0] = '{2'd1, 5'd0,  2, 0, 10, 0, 22, 0};
        tbl[1] = '{2'd0, 5'd3,  0, 1, 0,  0, 15, 0};
        tbl[2] = '{2'd0, 5'd0,  0, 0, 0,  0, 2,  1};
        tbl[3] = '{2'd0, 5'd17, 0, 0, 0,  0, 2,  1};
        tbl[4] = '{2'd2, 5'd9,  0, 0, 0,  0, 6,  0};
        tbl[5] = '{2'd3, 5'd0,  1, 0, 3,  1, 12, 0};
        tbl[6] = '{2'd0, 5'd16, 0, 0, 0,  0, 38, 0};
        tbl[7] = '{2'd0, 5'd1,  1, 2, 2,  0, 16, 0};
        tbl[8] = '{2'd0, 5'd31, 0, 0, 0,  0, 2,  1};
        tbl[9] = '{2'd1, 5'd5,  0, 0, 0,  1, 6,  0};

        repeat (3) @(negedge SCL);
        #1;
        chk("rst_ready", int'(cmdReady), 1);
        chk("rst_outs", int'({byteValid, dataReq, done, err, selData, selAA, sel55, selB0, selC0, selD0, selE0}), 0);
        @(negedge SCL);
        #1;
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            ack_d = tbl[k].ack; av_d = tbl[k].av; busy_n = tbl[k].busy;
            run(tbl[k].op, tbl[k].len, tbl[k].hold, tbl[k].lat, tbl[k].err);
        end

        // Reset during the second data byte of a 4-byte PROGRAM.
        ack_d = 0; av_d = 0; busy_n = 0;
        got.delete();
        ndone = 0;
        exp_n = 7;
        issue(2'd0, 5'd4, t0);
        cmdValid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge SCL);
            #1;
            if (got.size() >= 4 && selData) break;
        end
        chk("rst_mid_in_data", int'(selData), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", int'({byteValid, dataReq, done, err, selData, selAA, sel55, selB0, selC0, selD0, selE0}), 0);
        chk("rst_async_ready", int'(cmdReady), 1);
        repeat (2) @(negedge SCL);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) @(posedge SCL);
        #1;
        chk("rst_no_done", ndone, 0);
        chk("rst_ready_after", int'(cmdReady), 1);
        prev_err = 0;

        // Flash busy stuck high after SECTOR_ERASE.
        got.delete();
        ndone = 0;
        exp_n = 3;
        stuck = 1;
        issue(2'd1, 5'd0, t0);
        cmdValid = 1'b0;
`ifdef FLASH_SEQ_TIMEOUT_EN
        for (int i = 0; i < 200 && ndone == 0; i++) @(posedge SCL);
        #1;
        chk("tmo_done", ndone, 1);
        chk("tmo_latency", done_cyc - t0 + 1, 21);
        chk("tmo_err", int'(err_at_done), 1);
        stuck = 0;
        prev_err = 1;
`else
        repeat (1000) @(posedge SCL);
        #1;
        chk("no_tmo_done", ndone, 0);
        chk("no_tmo_err", int'(err), 0);
        stuck = 0;
        for (int i = 0; i < 50 && ndone == 0; i++) @(posedge SCL);
        #1;
        chk("busy_release_done", ndone, 1);
        prev_err = 0;
`endif
        repeat (2) @(posedge SCL);

        // Random commands with stray acks, checked against the model.
        stray = 1;
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [4:0] len;
            bit         h;
            op = 2'($urandom_range(0, 3));
            len = 5'($urandom_range(0, 17));
            ack_d = $urandom_range(0, 3);
            av_d = $urandom_range(0, 3);
            busy_n = $urandom_range(0, 5);
            h = !is_bad(op, len) && $urandom_range(0, 1) == 1;
            run(op, len, h, lat_model(op, len, ack_d, av_d, busy_n), is_bad(op, len));
        end
        stray = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
